// File: rtl/adc_spi_scanner.sv
// Multi-channel SPI-master ADC poller: sweeps the enabled channels, extracts a
// sample field from each frame and keeps one averaged result per channel.
module adc_spi_scanner #(
    parameter int N_CH       = 2,
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int DATA_LSB   = 3,
    parameter int CLK_DIV    = 2,
    parameter int AVG_LOG2   = 2,
    parameter int MODE       = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [N_CH-1:0]      ch_mask,
    input  logic [2:0]           rd_ch,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 adc_sck,
    output logic [N_CH-1:0]      adc_sce,
    input  logic                 adc_sin,
    output logic                 adc_sout
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW = DATA_BITS + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int SW = DATA_LSB + DATA_BITS;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [5:0]    BIT_LAST = 6'(FRAME_BITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t          state, state_n;
    logic [DW-1:0]   div_cnt, div_n;
    logic            sck_hi, sck_hi_n;
    logic [5:0]      bit_cnt, bit_n;
    logic [2:0]      ch, ch_n;
    logic [SW-1:0]   shreg;
    logic            shift_en, frame_end, sweep_end, div_last;
    logic            first_found, next_found;
    logic [2:0]      first_ch, next_ch;
    logic            sck_n, mosi_n;
    logic [N_CH-1:0] cs_n;
    logic [3:0]      hdr;

    logic [AW-1:0]        acc [N_CH];
    logic [CW-1:0]        cnt [N_CH];
    logic [DATA_BITS-1:0] res [N_CH];
    logic [N_CH-1:0]      vld;
    logic [DATA_BITS-1:0] sample;
    logic [AW-1:0]        acc_sel, sum;
    logic [CW-1:0]        cnt_sel;

    assign busy   = (state != IDLE);
    assign sample = shreg[SW-1:DATA_LSB];

    // Lowest enabled channel overall, and lowest enabled channel above the current one.
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_found = 1'b1;
                first_ch    = 3'(i);
            end
            if (ch_mask[i] && (3'(i) > ch)) begin
                next_found = 1'b1;
                next_ch    = 3'(i);
            end
        end
    end

    always_comb begin
        state_n   = state;
        div_n     = div_cnt;
        sck_hi_n  = sck_hi;
        bit_n     = bit_cnt;
        ch_n      = ch;
        shift_en  = 1'b0;
        frame_end = 1'b0;
        sweep_end = 1'b0;
        div_last  = (div_cnt == DIV_LAST);
        if (!ena) begin
            state_n  = IDLE;
            div_n    = '0;
            sck_hi_n = 1'b0;
            bit_n    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((start || continuous) && first_found) begin
                        state_n  = SETUP;
                        ch_n     = first_ch;
                        div_n    = '0;
                        sck_hi_n = 1'b0;
                        bit_n    = '0;
                    end
                end
                SETUP: begin
                    div_n = div_cnt + 1'b1;
                    if (div_last) begin
                        state_n = SHIFT;
                        div_n   = '0;
                    end
                end
                SHIFT: begin
                    div_n = div_cnt + 1'b1;
                    if (div_last) begin
                        div_n = '0;
                        if (!sck_hi) begin
                            sck_hi_n = 1'b1;
                            shift_en = 1'b1;
                        end else begin
                            sck_hi_n = 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state_n = HOLD;
                                bit_n   = '0;
                            end else begin
                                bit_n = bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    div_n = div_cnt + 1'b1;
                    if (div_last) begin
                        state_n   = GAP;
                        div_n     = '0;
                        frame_end = 1'b1;
                    end
                end
                GAP: begin
                    div_n = div_cnt + 1'b1;
                    if (div_last) begin
                        div_n = '0;
                        if (next_found) begin
                            state_n = SETUP;
                            ch_n    = next_ch;
                        end else begin
                            sweep_end = 1'b1;
                            if (continuous && first_found) begin
                                state_n = SETUP;
                                ch_n    = first_ch;
                            end else begin
                                state_n = IDLE;
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Pin values are derived from the next state so the pins are glitch-free flops.
    always_comb begin
        hdr    = {1'b1, ch_n} << bit_n[1:0];
        sck_n  = (state_n == SHIFT) && sck_hi_n;
        mosi_n = (MODE == 1) && ((state_n == SETUP) || (state_n == SHIFT)) &&
                 (bit_n < 6'd4) && hdr[3];
        cs_n   = '1;
        if ((state_n == SETUP) || (state_n == SHIFT) || (state_n == HOLD)) begin
            if (MODE == 1) begin
                cs_n[0] = 1'b0;
            end else begin
                for (int i = 0; i < N_CH; i++) begin
                    if (3'(i) == ch_n) cs_n[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            sck_hi   <= 1'b0;
            bit_cnt  <= '0;
            ch       <= '0;
            shreg    <= '0;
            adc_sck  <= 1'b0;
            adc_sce  <= '1;
            adc_sout <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            sck_hi   <= sck_hi_n;
            bit_cnt  <= bit_n;
            ch       <= ch_n;
            adc_sck  <= sck_n;
            adc_sce  <= cs_n;
            adc_sout <= mosi_n;
            done     <= sweep_end;
            if (shift_en) shreg <= {shreg[SW-2:0], adc_sin};
        end
    end

    always_comb begin
        acc_sel = '0;
        cnt_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (3'(i) == ch) begin
                acc_sel = acc[i];
                cnt_sel = cnt[i];
            end
        end
        sum = acc_sel + AW'(sample);
    end

    // The last sample of a block is folded in and the result published in one step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
                res[i] <= '0;
            end
            vld <= '0;
        end else if (frame_end) begin
            for (int i = 0; i < N_CH; i++) begin
                if (3'(i) == ch) begin
                    if (cnt_sel == CNT_LAST) begin
                        res[i] <= DATA_BITS'(sum >> AVG_LOG2);
                        vld[i] <= 1'b1;
                        acc[i] <= '0;
                        cnt[i] <= '0;
                    end else begin
                        acc[i] <= sum;
                        cnt[i] <= cnt_sel + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == 3'(i)) begin
                rd_data  = res[i];
                rd_valid = vld[i];
            end
        end
    end
endmodule

// File: tb/tb_adc_spi_scanner.sv
// Directed bench for adc_spi_scanner: three instances (no averaging, 4-sample
// averaging, shared-CS addressed mode) driven by SPI slave models.
module tb_adc_spi_scanner;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] exp_q[$];

    // ---------------- instance a: AVG_LOG2=0, MODE 0, 2 channels
    logic ena_a, start_a, cont_a, rd_valid_a, busy_a, done_a, sck_a, sin_a, sout_a;
    logic [1:0] mask_a, sce_a;
    logic [2:0] rd_ch_a;
    logic [11:0] rd_data_a;

    adc_spi_scanner #(.N_CH(2), .AVG_LOG2(0), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .ena(ena_a), .start(start_a), .continuous(cont_a),
        .ch_mask(mask_a), .rd_ch(rd_ch_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .busy(busy_a), .done(done_a), .adc_sck(sck_a), .adc_sce(sce_a),
        .adc_sin(sin_a), .adc_sout(sout_a)
    );

    // ---------------- instance b: defaults (4-sample averaging)
    logic ena_b, start_b, cont_b, rd_valid_b, busy_b, done_b, sck_b, sin_b, sout_b;
    logic [1:0] mask_b, sce_b;
    logic [2:0] rd_ch_b;
    logic [11:0] rd_data_b;

    adc_spi_scanner u_b (
        .clk(clk), .rst_n(rst_n), .ena(ena_b), .start(start_b), .continuous(cont_b),
        .ch_mask(mask_b), .rd_ch(rd_ch_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .busy(busy_b), .done(done_b), .adc_sck(sck_b), .adc_sce(sce_b),
        .adc_sin(sin_b), .adc_sout(sout_b)
    );

    // ---------------- instance c: MODE 1, 4 channels, no averaging
    logic ena_c, start_c, cont_c, rd_valid_c, busy_c, done_c, sck_c, sin_c, sout_c;
    logic [3:0] mask_c, sce_c;
    logic [2:0] rd_ch_c;
    logic [11:0] rd_data_c;

    adc_spi_scanner #(.N_CH(4), .AVG_LOG2(0), .MODE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .ena(ena_c), .start(start_c), .continuous(cont_c),
        .ch_mask(mask_c), .rd_ch(rd_ch_c), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
        .busy(busy_c), .done(done_c), .adc_sck(sck_c), .adc_sce(sce_c),
        .adc_sin(sin_c), .adc_sout(sout_c)
    );

    function automatic logic [15:0] mk_frame(input logic [11:0] s);
        return {1'b1, s, 3'b101};
    endfunction

    function automatic logic [11:0] sample_of(input logic [15:0] f);
        return f[14:3];
    endfunction

    // Slave models: load a frame when CS falls, present the MSB, advance on SCK fall.
    logic [15:0] frame_a0, frame_a1, cur_a;
    int k_a = 0, sck_rise_a = 0, cs0_low_a = 0, cs1_low_a = 0, busy_cnt_a = 0, done_cnt_a = 0;
    logic sck_prev_a = 1'b0, cs_prev_a = 1'b1;
    always @(negedge clk) begin
        if (cs_prev_a && !(&sce_a)) cur_a = !sce_a[0] ? frame_a0 : frame_a1;
        if (&sce_a) k_a = 0;
        else if (sck_prev_a && !sck_a) k_a++;
        if (sck_a && !sck_prev_a) sck_rise_a++;
        sin_a = (k_a < 16) ? cur_a[15 - k_a] : 1'b0;
        if (sce_a[0] === 1'b0) cs0_low_a++;
        if (sce_a[1] === 1'b0) cs1_low_a++;
        if (busy_a === 1'b1) busy_cnt_a++;
        if (done_a === 1'b1) done_cnt_a++;
        sck_prev_a = sck_a;
        cs_prev_a  = &sce_a;
    end

    logic [15:0] frames_b [4];
    logic [15:0] cur_b;
    int k_b = 0, idx_b = 0, done_cnt_b = 0;
    logic sck_prev_b = 1'b0, cs_prev_b = 1'b1;
    always @(negedge clk) begin
        if (cs_prev_b && !(&sce_b)) begin
            cur_b = (idx_b < 4) ? frames_b[idx_b] : 16'h0;
            idx_b++;
        end
        if (&sce_b) k_b = 0;
        else if (sck_prev_b && !sck_b) k_b++;
        sin_b = (k_b < 16) ? cur_b[15 - k_b] : 1'b0;
        if (done_b === 1'b1) done_cnt_b++;
        sck_prev_b = sck_b;
        cs_prev_b  = &sce_b;
    end

    logic [15:0] frame_c, cur_c;
    logic [3:0] mosi_bits_c = 4'h0;
    int k_c = 0, rise_c = 0, cs0_low_c = 0, cs_other_c = 0, late_mosi_c = 0, done_cnt_c = 0;
    logic sck_prev_c = 1'b0, cs_prev_c = 1'b1;
    always @(negedge clk) begin
        if (cs_prev_c && !(&sce_c)) begin
            cur_c  = frame_c;
            rise_c = 0;
        end
        if (&sce_c) k_c = 0;
        else if (sck_prev_c && !sck_c) k_c++;
        if (sck_c && !sck_prev_c) begin
            if (rise_c < 4) mosi_bits_c = {mosi_bits_c[2:0], sout_c};
            else if (sout_c !== 1'b0) late_mosi_c++;
            rise_c++;
        end
        sin_c = (k_c < 16) ? cur_c[15 - k_c] : 1'b0;
        if (sce_c[0] === 1'b0) cs0_low_c++;
        if (sce_c[3:1] !== 3'b111) cs_other_c++;
        if (done_c === 1'b1) done_cnt_c++;
        sck_prev_c = sck_c;
        cs_prev_c  = &sce_c;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [11:0] got);
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, got, e);
        end
    endtask

    task automatic wait_done(input int inst, input int target, input string tag);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ((inst == 0 && done_cnt_a >= target) || (inst == 1 && done_cnt_b >= target) ||
                (inst == 2 && done_cnt_c >= target)) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_rise_a(input int target, input string tag);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (sck_rise_a >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic pulse_start_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    int b_rise, b_cs0, b_cs1, b_busy, b_done;
    task automatic snap_a;
        b_rise = sck_rise_a;
        b_cs0  = cs0_low_a;
        b_cs1  = cs1_low_a;
        b_busy = busy_cnt_a;
        b_done = done_cnt_a;
    endtask

    initial begin
        rst_n = 1'b0;
        ena_a = 1'b1; start_a = 1'b0; cont_a = 1'b0; mask_a = 2'b00; rd_ch_a = 3'd0;
        ena_b = 1'b1; start_b = 1'b0; cont_b = 1'b0; mask_b = 2'b00; rd_ch_b = 3'd0;
        ena_c = 1'b1; start_c = 1'b0; cont_c = 1'b0; mask_c = 4'b0000; rd_ch_c = 3'd0;
        frame_a0 = 16'h0; frame_a1 = 16'h0; frame_c = 16'h0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_sce_a", 32'(sce_a), 32'h3);
        check("rst_sck_a", 32'(sck_a), 32'h0);
        check("rst_busy_a", 32'(busy_a), 32'h0);
        check("rst_done_a", 32'(done_a), 32'h0);
        check("rst_sout_b", 32'(sout_b), 32'h0);
        check("rst_sce_c", 32'(sce_c), 32'hF);
        rd_ch_a = 3'd0; #1;
        check("rst_valid_ch0", 32'(rd_valid_a), 32'h0);
        rd_ch_a = 3'd1; #1;
        check("rst_valid_ch1", 32'(rd_valid_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single frame on ch0
        frame_a0 = 16'h5A58;
        mask_a   = 2'b01;
        snap_a();
        exp_q.push_back(12'hB4B);
        pulse_start_a();
        wait_done(0, b_done + 1, "done_ch0_frame");
        repeat (4) @(negedge clk);
        check("sck_rises_ch0", 32'(sck_rise_a - b_rise), 32'd16);
        check("cs0_low_cycles", 32'(cs0_low_a - b_cs0), 32'd68);
        check("cs1_never_low", 32'(cs1_low_a - b_cs1), 32'd0);
        check("done_once_ch0", 32'(done_cnt_a - b_done), 32'd1);
        check("idle_after_ch0", 32'(busy_a), 32'd0);
        rd_ch_a = 3'd0; #1;
        check("valid_ch0", 32'(rd_valid_a), 32'd1);
        sb_check("data_ch0", rd_data_a);
        @(negedge clk);

        // only ch1 enabled, random frame; a start during the sweep is ignored
        frame_a1 = 16'($urandom_range(0, 16'hFFFF));
        mask_a   = 2'b10;
        snap_a();
        exp_q.push_back(sample_of(frame_a1));
        pulse_start_a();
        repeat (20) @(negedge clk);
        pulse_start_a();
        wait_done(0, b_done + 1, "done_ch1_frame");
        repeat (100) @(negedge clk);
        check("done_once_ch1", 32'(done_cnt_a - b_done), 32'd1);
        check("cs0_quiet_ch1", 32'(cs0_low_a - b_cs0), 32'd0);
        check("cs1_low_cycles", 32'(cs1_low_a - b_cs1), 32'd68);
        check("sck_rises_ch1", 32'(sck_rise_a - b_rise), 32'd16);
        rd_ch_a = 3'd1; #1;
        check("valid_ch1", 32'(rd_valid_a), 32'd1);
        sb_check("data_ch1", rd_data_a);
        rd_ch_a = 3'd0; #1;
        check("ch0_kept", 32'(rd_data_a), 32'hB4B);
        rd_ch_a = 3'd2; #1;
        check("rd_oob_data_a", 32'(rd_data_a), 32'd0);
        check("rd_oob_valid_a", 32'(rd_valid_a), 32'd0);
        @(negedge clk);

        // empty mask: start does nothing
        mask_a = 2'b00;
        snap_a();
        pulse_start_a();
        repeat (30) @(negedge clk);
        check("mask0_busy", 32'(busy_cnt_a - b_busy), 32'd0);
        check("mask0_done", 32'(done_cnt_a - b_done), 32'd0);

        // ena dropped in the 5th SCK period
        mask_a   = 2'b01;
        frame_a0 = 16'hFFFF;
        snap_a();
        pulse_start_a();
        wait_rise_a(b_rise + 5, "reach_5th_sck");
        ena_a = 1'b0;
        @(negedge clk);
        check("abort_sce", 32'(sce_a), 32'h3);
        check("abort_sck", 32'(sck_a), 32'h0);
        check("abort_busy", 32'(busy_a), 32'h0);
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_cnt_a - b_done), 32'd0);
        rd_ch_a = 3'd0; #1;
        check("abort_data_kept", 32'(rd_data_a), 32'hB4B);
        check("abort_valid_kept", 32'(rd_valid_a), 32'd1);
        ena_a = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_stays_idle", 32'(busy_a), 32'd0);

        // 4-sample averaging in continuous mode
        frames_b[0] = mk_frame(12'd100);
        frames_b[1] = mk_frame(12'd101);
        frames_b[2] = mk_frame(12'd102);
        frames_b[3] = mk_frame(12'd104);
        exp_q.push_back(12'((100 + 101 + 102 + 104) / 4));
        mask_b  = 2'b01;
        rd_ch_b = 3'd0;
        cont_b  = 1'b1;
        wait_done(1, 1, "avg_sweep1");
        check("avg_valid_s1", 32'(rd_valid_b), 32'd0);
        wait_done(1, 2, "avg_sweep2");
        check("avg_valid_s2", 32'(rd_valid_b), 32'd0);
        wait_done(1, 3, "avg_sweep3");
        check("avg_valid_s3", 32'(rd_valid_b), 32'd0);
        cont_b = 1'b0;
        wait_done(1, 4, "avg_sweep4");
        repeat (10) @(negedge clk);
        check("avg_valid_s4", 32'(rd_valid_b), 32'd1);
        sb_check("avg_data", rd_data_b);
        check("avg_idle", 32'(busy_b), 32'd0);
        check("avg_done_count", 32'(done_cnt_b), 32'd4);

        // shared-CS mode, channel 2
        frame_c = 16'hA5C3;
        mask_c  = 4'b0100;
        exp_q.push_back(sample_of(frame_c));
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        wait_done(2, 1, "m1_done");
        repeat (4) @(negedge clk);
        check("m1_mosi_header", 32'(mosi_bits_c), 32'hA);
        check("m1_mosi_tail_zero", 32'(late_mosi_c), 32'd0);
        check("m1_other_cs_high", 32'(cs_other_c), 32'd0);
        check("m1_cs0_low_cycles", 32'(cs0_low_c), 32'd68);
        rd_ch_c = 3'd2; #1;
        check("m1_valid_ch2", 32'(rd_valid_c), 32'd1);
        sb_check("m1_data_ch2", rd_data_c);
        rd_ch_c = 3'd0; #1;
        check("m1_valid_ch0", 32'(rd_valid_c), 32'd0);
        rd_ch_c = 3'd5; #1;
        check("m1_oob_data", 32'(rd_data_c), 32'd0);
        check("m1_oob_valid", 32'(rd_valid_c), 32'd0);
        @(negedge clk);

        // asynchronous reset mid-frame
        frame_a0 = 16'h0F0F;
        mask_a   = 2'b01;
        snap_a();
        pulse_start_a();
        wait_rise_a(b_rise + 3, "reach_3rd_sck");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sce", 32'(sce_a), 32'h3);
        check("arst_sck", 32'(sck_a), 32'h0);
        check("arst_busy", 32'(busy_a), 32'h0);
        rd_ch_a = 3'd0; #1;
        check("arst_valid", 32'(rd_valid_a), 32'd0);
        check("arst_data", 32'(rd_data_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_spi_scanner.md
Name: adc_spi_scanner

Overview:
- Parametrised SPI-master ADC poller. Successor to the single-channel thermocouple ADC reader.
- Sweeps up to N_CH converter channels and extracts a DATA_BITS field from each FRAME_BITS-bit frame.
- Averages 2^AVG_LOG2 samples per channel and holds one result register per channel, readable through a mux port.
- Sits between the tile's uio ADC pins and the register/SPI-slave logic.

Parameters:
- N_CH, 2, number of channels (1..8)
- FRAME_BITS, 16, SCK cycles per frame (8..32)
- DATA_BITS, 12, width of extracted sample
- DATA_LSB, 3, bit index of the sample LSB within the received frame (frame bit 0 = last bit received)
- CLK_DIV, 2, clk cycles per SCK half-period (>=1)
- AVG_LOG2, 2, log2 of samples averaged per result (0..4)
- MODE, 0, 0 = one chip-select per channel; 1 = shared adc_sce[0] with channel index sent on MOSI

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable; low aborts any frame
- start  in  1  one-cycle pulse, begins one sweep when idle
- continuous  in  1  when high, a new sweep starts automatically after each sweep
- ch_mask  in  N_CH  channel enables
- rd_ch  in  3  result read select
- rd_data  out  DATA_BITS  averaged result of channel rd_ch (combinational mux)
- rd_valid  out  1  channel rd_ch has a result since reset
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at end of each sweep
- adc_sck  out  1  SPI clock, mode 0, idle low
- adc_sce  out  N_CH  chip selects, active low
- adc_sin  in  1  ADC MISO
- adc_sout  out  1  ADC MOSI

Behaviour:
- Reset values: adc_sck=0, adc_sce=all 1, adc_sout=0, busy=0, done=0. All results, valid bits, accumulators and counters are 0.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE -> SETUP: on (start | continuous) & ena & |ch_mask. Channel pointer goes to the lowest enabled channel. start while busy is ignored. ch_mask is sampled once per frame, at SETUP entry.
- SETUP lasts CLK_DIV cycles. Selected CS is low and SCK is low.
- SHIFT lasts FRAME_BITS SCK periods, each CLK_DIV cycles low then CLK_DIV high. MISO is sampled on each SCK rising edge and shifted in MSB-first. MOSI changes only while SCK is low.
- HOLD lasts CLK_DIV cycles with CS still low. At HOLD exit, CS goes high and the sample is latched.
- GAP lasts CLK_DIV cycles with all CS high.
- After GAP: go to SETUP for the next higher enabled channel. If none remains, pulse done, then go to IDLE, or straight to SETUP when continuous & ena.
- CS low time per frame = CLK_DIV*(2*FRAME_BITS+2) cycles.
- MODE 0: CS is adc_sce[ch]. adc_sout is held 0.
- MODE 1: CS is adc_sce[0]; other CS bits stay 1. adc_sout sends a 1 start bit followed by the 3-bit channel index, MSB-first, over the first 4 SCK periods, then 0. The frame still lasts FRAME_BITS SCK periods.
- Sample = frame[DATA_LSB +: DATA_BITS], unsigned.
- Per-channel accumulator is DATA_BITS+AVG_LOG2 bits wide, with a per-channel count.
- When the count reaches 2^AVG_LOG2: result = acc >> AVG_LOG2 (truncating), valid set, acc and count cleared in the same cycle.
- AVG_LOG2=0: every frame updates the result directly.
- ena low at any point: return to IDLE on the next clk edge. CS goes all-high and SCK low, and the partial frame is discarded. Results, valid bits and accumulators are kept. No done pulse.
- rd_ch >= N_CH: rd_data=0 and rd_valid=0.
- Asynchronous reset mid-frame forces every output to its reset value immediately.

Test Plan:
- Reset with defaults -> adc_sce=2'b11, adc_sck=0, busy=0, rd_valid=0 for rd_ch=0 and rd_ch=1.
- AVG_LOG2=0, ch_mask=01, start, MISO model returns 16'h5A58 -> exactly 16 SCK rising edges; adc_sce[0] low for 68 cycles; rd_data(ch0)=12'hB4B; rd_valid=1; one done pulse; adc_sce[1] never low.
- AVG_LOG2=2, continuous=1, ch0 samples 100, 101, 102, 104 -> rd_valid(ch0) stays 0 through the first 3 sweeps; after the 4th sweep rd_data=101.
- ch_mask=10 -> only adc_sce[1] toggles and only ch1 updates. ch_mask=00 with start -> busy stays 0 and no done pulse.
- ena dropped during the 5th SCK period -> all CS high and SCK low next cycle; previous result and valid unchanged; no done pulse.
- MODE=1, N_CH=4, ch_mask=4'b0100 -> only adc_sce[0] toggles; adc_sout carries bits 1,0,1,0 on the first 4 SCK rising edges; the result lands in ch2.
